// File: rtl/fixed_point_run_controller.sv
// Fixed-point run sequencer for an 8-bit boolean-network state register.
// Define FPRC_CYCLE_DETECT_EN to end runs on period-2 oscillation (osc).
module fixed_point_run_controller #(
  parameter int MAX_STEPS = 255,
  parameter int STEP_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [0:7]        seed,
  input  logic [0:7]        next_status,
  output logic [0:7]        status,
  output logic              busy,
  output logic              done,
  output logic              fixed,
  output logic              timeout,
  output logic              osc,
  output logic [STEP_W-1:0] steps
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

  logic [1:0] state;
  logic       is_fix;
  logic       at_max;
  logic       is_osc;

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign is_fix = (next_status == status);
  assign at_max = (steps == STEP_MAX);

`ifdef FPRC_CYCLE_DETECT_EN
  logic [0:7] prev;
  logic       osc_q;

  assign is_osc = (steps != '0) && (next_status == prev);
  assign osc    = osc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= '0;
      osc_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) osc_q <= 1'b0;
        end
        S_RUN: begin
          if (abort) begin
            osc_q <= 1'b0;
          end else if (!is_fix) begin
            if (is_osc) osc_q <= 1'b1;
            else if (!at_max) prev <= status;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign is_osc = 1'b0;
  assign osc    = 1'b0;
`endif

  // Priority in RUN: abort, fixed point, oscillation, step limit, update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      status  <= '0;
      steps   <= '0;
      fixed   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_RUN;
            status  <= seed;
            steps   <= '0;
            fixed   <= 1'b0;
            timeout <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state   <= S_IDLE;
            fixed   <= 1'b0;
            timeout <= 1'b0;
          end else if (is_fix) begin
            state <= S_DONE;
            fixed <= 1'b1;
          end else if (is_osc) begin
            state <= S_DONE;
          end else if (at_max) begin
            state   <= S_DONE;
            timeout <= 1'b1;
          end else begin
            status <= next_status;
            steps  <= steps + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
